// File: rtl/median_window_filter.sv
// 3x3 greyscale median filter over an IMG_WIDTH x IMG_HEIGHT frame, fetched sample by sample from external memory.
// Optional changed-pixel counter enabled by defining MEDIAN_CHANGE_COUNT_EN.
module median_window_filter #(
  parameter int IMG_WIDTH   = 128,
  parameter int IMG_HEIGHT  = 128,
  parameter int ADDR_W      = 8,
  parameter int PIX_W       = 8,
  parameter int READ_LAT    = 1,
  parameter int BORDER_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  dataIn,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic [ADDR_W-1:0] xMedianAddress,
  output logic [ADDR_W-1:0] yMedianAddress,
  output logic [PIX_W-1:0]  dataOut,
  output logic              writeEnable,
  output logic              filterReady,
  output logic              filterDone
`ifdef MEDIAN_CHANGE_COUNT_EN
  ,
  output logic [2*ADDR_W-1:0] changedCount
`endif
);

  localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMG_HEIGHT - 1);
  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_px, r_py;
  logic [ADDR_W-1:0]   r_xa, r_ya, r_xm, r_ym;
  logic [PIX_W-1:0]    r_dout;
  logic                r_we, r_ready, r_done;
  logic [3:0]          r_k;
  logic [3:0]          r_cap_idx;
  logic [DW-1:0]       r_dcnt;
  logic                r_aval;
  logic [READ_LAT-1:0] r_vpipe;
  logic [PIX_W-1:0]    r_s [9];
  logic [PIX_W-1:0]    r_centre;
`ifdef MEDIAN_CHANGE_COUNT_EN
  logic [2*ADDR_W-1:0] r_changed;
`endif

  logic                w_capture;
  logic [8:0]          w_le;
  logic [PIX_W-1:0]    w_s_next [9];
  logic                w_last, w_edge;
  logic [ADDR_W-1:0]   w_nx, w_ny;

  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] c,
                                             input logic [1:0] d,
                                             input logic [ADDR_W-1:0] cmax);
    case (d)
      2'd0:    step = (c == '0) ? c : c - 1'b1;
      2'd2:    step = (c == cmax) ? c : c + 1'b1;
      default: step = c;
    endcase
  endfunction

  // Returns {y, x} of window sample k around (px, py) with edge clamping.
  function automatic logic [2*ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] px,
                                                   input logic [ADDR_W-1:0] py,
                                                   input logic [3:0] k);
    logic [1:0] dx, dy;
    case (k)
      4'd0:    begin dy = 2'd0; dx = 2'd0; end
      4'd1:    begin dy = 2'd0; dx = 2'd1; end
      4'd2:    begin dy = 2'd0; dx = 2'd2; end
      4'd3:    begin dy = 2'd1; dx = 2'd0; end
      4'd4:    begin dy = 2'd1; dx = 2'd1; end
      4'd5:    begin dy = 2'd1; dx = 2'd2; end
      4'd6:    begin dy = 2'd2; dx = 2'd0; end
      4'd7:    begin dy = 2'd2; dx = 2'd1; end
      default: begin dy = 2'd2; dx = 2'd2; end
    endcase
    win_addr = {step(py, dy, YMAX), step(px, dx, XMAX)};
  endfunction

  assign w_capture = r_vpipe[READ_LAT-1];
  assign w_last    = (r_px == XMAX) && (r_py == YMAX);
  assign w_edge    = (r_px == '0) || (r_px == XMAX) || (r_py == '0) || (r_py == YMAX);
  assign w_nx      = (r_px == XMAX) ? '0 : r_px + 1'b1;
  assign w_ny      = (r_px == XMAX) ? r_py + 1'b1 : r_py;

  // Insertion over the occupied prefix: w_le marks the sorted run of entries <= dataIn,
  // so dataIn lands just after equal values and larger entries move up one slot.
  always_comb begin
    for (int unsigned i = 0; i < 9; i++)
      w_le[i] = (4'(i) < r_cap_idx) && (r_s[i] <= dataIn);
    w_s_next[0] = w_le[0] ? r_s[0] : dataIn;
    for (int unsigned i = 1; i < 9; i++) begin
      if (w_le[i])        w_s_next[i] = r_s[i];
      else if (w_le[i-1]) w_s_next[i] = dataIn;
      else                w_s_next[i] = r_s[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_px      <= '0;
      r_py      <= '0;
      r_xa      <= '0;
      r_ya      <= '0;
      r_xm      <= '0;
      r_ym      <= '0;
      r_dout    <= '0;
      r_we      <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_k       <= '0;
      r_cap_idx <= '0;
      r_dcnt    <= '0;
      r_aval    <= 1'b0;
      r_vpipe   <= '0;
      r_centre  <= '0;
      for (int unsigned i = 0; i < 9; i++) r_s[i] <= '0;
`ifdef MEDIAN_CHANGE_COUNT_EN
      r_changed <= '0;
`endif
    end else begin
      r_vpipe[0] <= r_aval;
      for (int unsigned i = 1; i < READ_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];

      if (w_capture) begin
        r_cap_idx <= r_cap_idx + 1'b1;
        for (int unsigned i = 0; i < 9; i++) r_s[i] <= w_s_next[i];
        if (r_cap_idx == 4'd4) r_centre <= dataIn;
      end

      r_we   <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_FETCH;
            r_ready      <= 1'b0;
            r_px         <= '0;
            r_py         <= '0;
            {r_ya, r_xa} <= win_addr('0, '0, 4'd0);
            r_aval       <= 1'b1;
            r_k          <= 4'd1;
            r_cap_idx    <= '0;
            for (int unsigned i = 0; i < 9; i++) r_s[i] <= '0;
`ifdef MEDIAN_CHANGE_COUNT_EN
            r_changed    <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (r_k == 4'd9) begin
            r_state <= S_DRAIN;
            r_aval  <= 1'b0;
            r_dcnt  <= '0;
          end else begin
            {r_ya, r_xa} <= win_addr(r_px, r_py, r_k);
            r_k          <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DW'(READ_LAT - 1)) begin
            // The ninth sample is inserted on this same edge, so the median comes from w_s_next.
            r_state <= S_WRITE;
            r_we    <= 1'b1;
            r_xm    <= r_px;
            r_ym    <= r_py;
            r_dout  <= ((BORDER_MODE == 1) && w_edge) ? r_centre : w_s_next[4];
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_WRITE: begin
`ifdef MEDIAN_CHANGE_COUNT_EN
          if ((r_dout != r_centre) && (r_changed != '1)) r_changed <= r_changed + 1'b1;
`endif
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_FETCH;
            r_px         <= w_nx;
            r_py         <= w_ny;
            {r_ya, r_xa} <= win_addr(w_nx, w_ny, 4'd0);
            r_aval       <= 1'b1;
            r_k          <= 4'd1;
            r_cap_idx    <= '0;
            for (int unsigned i = 0; i < 9; i++) r_s[i] <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign xAddressOut    = r_xa;
  assign yAddressOut    = r_ya;
  assign xMedianAddress = r_xm;
  assign yMedianAddress = r_ym;
  assign dataOut        = r_dout;
  assign writeEnable    = r_we;
  assign filterReady    = r_ready;
  assign filterDone     = r_done;
`ifdef MEDIAN_CHANGE_COUNT_EN
  assign changedCount   = r_changed;
`endif

endmodule
